mem_wr_sched: RTL and testbench

Parametrised write-address/enable sequencer for the banked input/weight memories feeding the systolic array. It accepts a start command with base address, row count and address stride, then issues one row write per accepted source beat to all SYS_ROW banks. Banks are written either in parallel or skewed one cycle per bank to match systolic wavefront timing. It is the successor to the fixed-width parallel write controller, adding stride, source flow control, a busy/done handshake and an optional skew mode.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_wr_skew_line.sv | 31 +++
 rtl/mem_wr_sched.sv | 176 +++++++++++++++++
 tb/tb_mem_wr_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the banked memory write sequencer.
// Provides the bank address type and the sequencer state encoding.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;

  typedef logic [MEM_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wr_state_e;

endpackage

// File: rtl/mem_wr_skew_line.sv
// Skew delay line: SYS_ROW-stage shift register of {en, addr}.
// Ports: clk, rst, in_en/in_addr (row write), tap_en/tap_addr (tap i -> bank i).
module mem_wr_skew_line
  import mem_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_en,
  input  logic [ADDR_WIDTH-1:0]                in_addr,
  output logic [SYS_ROW-1:0]                   tap_en,
  output logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]   tap_addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_en   <= '0;
      tap_addr <= '0;
    end else begin
      tap_en[0]   <= in_en;
      tap_addr[0] <= in_addr;
      for (int i = 1; i < SYS_ROW; i++) begin
        tap_en[i]   <= tap_en[i-1];
        tap_addr[i] <= tap_addr[i-1];
      end
    end
  end

endmodule

// File: rtl/mem_wr_sched.sv
// Write address/enable sequencer for banked array memories.
// Ports: start/base_addr/num_row/stride/skew_mode command, in_valid/in_ready
// source handshake, wr_en_out/wr_addr per bank, busy/done status.
// MEM_WR_SKEW_EN builds the skew delay line and honours skew_mode.
module mem_wr_sched
  import mem_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [CNT_WIDTH-1:0]                 num_row,
  input  logic [ADDR_WIDTH-1:0]                stride,
  input  logic                                 skew_mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [SYS_ROW-1:0]                   wr_en_out,
  output logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]   wr_addr,
  output logic                                 busy,
  output logic                                 done
);

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  row_cnt;
  logic                  row_en;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic                  acc;
  logic                  last;
  logic [ADDR_WIDTH-1:0] nxt_addr;

  assign acc      = in_valid & in_ready;
  assign last     = (row_cnt == num_q - CNT_WIDTH'(1));
  // Address forced to zero on idle beats so disabled banks read 0.
  assign nxt_addr = acc ? cur_addr : '0;

`ifdef MEM_WR_SKEW_EN
  localparam int DW = (SYS_ROW > 2) ? $clog2(SYS_ROW) : 1;
  // Last row leaves bank 0 on entry; bank SYS_ROW-1 sees it
  // SYS_ROW-1 edges later.
  localparam int DRAIN_LAST = (SYS_ROW > 1) ? SYS_ROW - 2 : 0;

  logic                                skew_q;
  logic [DW-1:0]                       dcnt;
  logic [SYS_ROW-1:0]                  tap_en;
  logic [SYS_ROW-1:0][ADDR_WIDTH-1:0]  tap_addr;

  mem_wr_skew_line #(
    .SYS_ROW    (SYS_ROW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skew (
    .clk      (clk),
    .rst      (rst),
    .in_en    (acc),
    .in_addr  (nxt_addr),
    .tap_en   (tap_en),
    .tap_addr (tap_addr)
  );
`else
  logic unused_skew;
  assign unused_skew = skew_mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_addr <= '0;
      stride_q <= '0;
      num_q    <= '0;
      row_cnt  <= '0;
      row_en   <= 1'b0;
      row_addr <= '0;
`ifdef MEM_WR_SKEW_EN
      skew_q   <= 1'b0;
      dcnt     <= '0;
`endif
    end else begin
      done     <= 1'b0;
      row_en   <= acc;
      row_addr <= nxt_addr;
      // busy stays up through the done cycle, drops after it.
      if (done) begin
        busy <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start && !busy) begin
            cur_addr <= base_addr;
            stride_q <= stride;
            num_q    <= num_row;
            row_cnt  <= '0;
            busy     <= 1'b1;
`ifdef MEM_WR_SKEW_EN
            skew_q   <= skew_mode;
`endif
            if (num_row == '0) begin
              done <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc) begin
            cur_addr <= cur_addr + stride_q;
            row_cnt  <= row_cnt + CNT_WIDTH'(1);
            if (last) begin
              in_ready <= 1'b0;
`ifdef MEM_WR_SKEW_EN
              if (skew_q) begin
                state <= DRAIN;
                dcnt  <= '0;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef MEM_WR_SKEW_EN
        DRAIN: begin
          if (dcnt == DW'(DRAIN_LAST)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_WR_SKEW_EN
  always_comb begin
    wr_en_out = '0;
    wr_addr   = '0;
    if (skew_q) begin
      wr_en_out = tap_en;
      wr_addr   = tap_addr;
    end else begin
      for (int i = 0; i < SYS_ROW; i++) begin
        wr_en_out[i] = row_en;
        wr_addr[i]   = row_addr;
      end
    end
  end
`else
  always_comb begin
    wr_en_out = '0;
    wr_addr   = '0;
    for (int i = 0; i < SYS_ROW; i++) begin
      wr_en_out[i] = row_en;
      wr_addr[i]   = row_addr;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wr_sched.sv
// Scoreboard bench for mem_wr_sched.
// Expected writes are queued at stimulus time; a monitor compares them.
module tb_mem_wr_sched;

  localparam int SR = 16;
  localparam int AW = 8;
  localparam int CW = 9;

  typedef struct {
    logic [SR-1:0]         en;
    logic [SR-1:0][AW-1:0] addr;
    logic                  dn;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [AW-1:0]         base_addr = '0;
  logic [CW-1:0]         num_row = '0;
  logic [AW-1:0]         stride = '0;
  logic                  skew_mode = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [SR-1:0]         wr_en_out;
  logic [SR-1:0][AW-1:0] wr_addr;
  logic                  busy;
  logic                  done;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wr_cycles = 0;
  logic mon_on = 1'b1;

  mem_wr_sched #(
    .SYS_ROW    (SR),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_row   (num_row),
    .stride    (stride),
    .skew_mode (skew_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en_out (wr_en_out),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act,
                       input logic [255:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_par(input logic [AW-1:0] a, input logic dn);
    exp_t e;
    e.en = '1;
    for (int i = 0; i < SR; i++) e.addr[i] = a;
    e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic push_zero();
    exp_t e;
    e.en = '0;
    e.addr = '0;
    e.dn = 1'b1;
    exp_q.push_back(e);
  endtask

  // Back-to-back rows, stride 1: bank i shows row k in cycle k+i.
  task automatic push_skew(input logic [AW-1:0] b, input int num);
    exp_t e;
    for (int c = 0; c < num + SR - 1; c++) begin
      e.en = '0;
      e.addr = '0;
      for (int i = 0; i < SR; i++) begin
        if (c - i >= 0 && c - i < num) begin
          e.en[i] = 1'b1;
          e.addr[i] = b + AW'(c - i);
        end
      end
      e.dn = (c == num + SR - 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic cmd(input logic [AW-1:0] b, input logic [CW-1:0] n,
                     input logic [AW-1:0] s, input logic sk);
    base_addr = b;
    num_row   = n;
    stride    = s;
    skew_mode = sk;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic beats(input logic [7:0] pat, input int len);
    for (int j = 0; j < len; j++) begin
      in_valid = pat[j];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, done, 1'b1);
    check({nm, "_busy_at_done"}, busy, 1'b1);
    tick();
    check({nm, "_busy_after"}, busy, 1'b0);
    check({nm, "_done_after"}, done, 1'b0);
    check({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && mon_on && (|wr_en_out || done)) begin
      if (|wr_en_out) wr_cycles++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {wr_en_out, done}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_wr_en", wr_en_out, e.en);
        check("mon_wr_addr", wr_addr, e.addr);
        check("mon_done", done, e.dn);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", wr_en_out, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    tick();

    // Parallel, contiguous
    wr_cycles = 0;
    push_par(8'h10, 1'b0);
    push_par(8'h11, 1'b0);
    push_par(8'h12, 1'b0);
    push_par(8'h13, 1'b1);
    cmd(8'h10, 9'd4, 8'd1, 1'b0);
    check("start_busy", busy, 1'b1);
    check("start_in_ready", in_ready, 1'b1);
    beats(8'h0F, 4);
    wait_done("par", 8);
    check("par_wr_cycles", wr_cycles, 4);
    tick();

    // Stride with address wrap
    wr_cycles = 0;
    push_par(8'hF8, 1'b0);
    push_par(8'hFC, 1'b0);
    push_par(8'h00, 1'b0);
    push_par(8'h04, 1'b1);
    cmd(8'hF8, 9'd4, 8'd4, 1'b0);
    beats(8'h0F, 4);
    wait_done("wrap", 8);
    check("wrap_wr_cycles", wr_cycles, 4);
    tick();

    // Backpressure 1,0,0,1,1
    wr_cycles = 0;
    push_par(8'h20, 1'b0);
    push_par(8'h21, 1'b0);
    push_par(8'h22, 1'b1);
    cmd(8'h20, 9'd3, 8'd1, 1'b0);
    beats(8'b11001, 5);
    wait_done("bp", 8);
    check("bp_wr_cycles", wr_cycles, 3);
    tick();

    // Zero-row command
    wr_cycles = 0;
    push_zero();
    cmd(8'h55, 9'd0, 8'd1, 1'b0);
    check("zero_in_ready", in_ready, 1'b0);
    wait_done("zero", 4);
    check("zero_wr_cycles", wr_cycles, 0);
    tick();

    // start while busy is ignored
    wr_cycles = 0;
    push_par(8'h40, 1'b0);
    push_par(8'h42, 1'b0);
    push_par(8'h44, 1'b1);
    cmd(8'h40, 9'd3, 8'd2, 1'b0);
    in_valid = 1'b1;
    tick();
    base_addr = 8'h80;
    num_row   = 9'd5;
    stride    = 8'd7;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick();
    in_valid  = 1'b0;
    wait_done("busy_start", 8);
    tick();
    tick();
    check("busy_start_wr_cycles", wr_cycles, 3);
    check("busy_start_idle", busy, 1'b0);

    // Skewed (or ignored skew in the parallel-only build)
    wr_cycles = 0;
`ifdef MEM_WR_SKEW_EN
    push_skew(8'h00, 2);
`else
    push_par(8'h00, 1'b0);
    push_par(8'h01, 1'b1);
`endif
    cmd(8'h00, 9'd2, 8'd1, 1'b1);
    beats(8'h03, 2);
    check("skew_in_ready_low", in_ready, 1'b0);
    check("skew_busy_held", busy, 1'b1);
    wait_done("skew", 24);
`ifdef MEM_WR_SKEW_EN
    check("skew_wr_cycles", wr_cycles, 17);
`else
    check("skew_wr_cycles", wr_cycles, 2);
`endif
    tick();

    // Reset mid-drain, then a clean command
    mon_on = 1'b0;
    cmd(8'h20, 9'd2, 8'd1, 1'b1);
    beats(8'h03, 2);
    tick();
    tick();
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("arst_wr_en", wr_en_out, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    wr_cycles = 0;
    mon_on = 1'b1;
    tick();
`ifdef MEM_WR_SKEW_EN
    push_skew(8'h30, 1);
`else
    push_par(8'h30, 1'b1);
`endif
    cmd(8'h30, 9'd1, 8'd1, 1'b1);
    beats(8'h01, 1);
    wait_done("post_rst", 24);
`ifdef MEM_WR_SKEW_EN
    check("post_rst_wr_cycles", wr_cycles, 16);
`else
    check("post_rst_wr_cycles", wr_cycles, 1);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
